// File: rtl/keyboard_pkg.sv
// Shared scancode constants, key code type and prefix-FSM state encoding
// for the PS/2 Set-2 keymap decoder.
package keyboard_pkg;

    localparam logic [7:0] SC_BREAK  = 8'hF0;
    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_BAT    = 8'hAA;
    localparam logic [7:0] SC_ACK    = 8'hFA;
    localparam logic [7:0] SC_ECHO   = 8'hEE;
    localparam logic [7:0] SC_RESEND = 8'hFE;
    localparam logic [7:0] SC_PAUSE  = 8'hE1;
    localparam logic [7:0] SC_ERR0   = 8'h00;
    localparam logic [7:0] SC_ERR1   = 8'hFF;

    localparam logic [7:0] KEY_LEFT  = 8'h1C;
    localparam logic [7:0] KEY_RIGHT = 8'h23;

    typedef struct packed {
        logic       ext;
        logic [7:0] code;
    } keycode_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BRK     = 2'd1,
        ST_EXT     = 2'd2,
        ST_EXT_BRK = 2'd3
    } kb_state_t;

    // BAT completion and buffer-overrun bytes invalidate every held key.
    function automatic logic is_clear_byte(input logic [7:0] b);
        return (b == SC_BAT) || (b == SC_ERR0) || (b == SC_ERR1);
    endfunction

    // Host-protocol responses that carry no key information.
    function automatic logic is_ignored_byte(input logic [7:0] b);
        return (b == SC_ACK) || (b == SC_ECHO) || (b == SC_RESEND) || (b == SC_PAUSE);
    endfunction

endpackage

// File: rtl/keyboard_prefix_fsm.sv
// Prefix tracker: folds F0/E0 prefixes into registered make/break/clear
// strobes with a 9-bit key code, and raises err on a stalled prefix.
module keyboard_prefix_fsm
    import keyboard_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       code_valid_i,
    input  logic [7:0] code_byte_i,
    output logic       make_o,
    output logic       break_o,
    output logic       clear_o,
    output logic       err_o,
    output keycode_t   code_o
);

    localparam int             CW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0]  CNT_MAX  = {CW{1'b1}};

    kb_state_t     state_q;
    logic [CW-1:0] cnt_q;
    logic          make_q;
    logic          break_q;
    logic          clear_q;
    logic          err_q;
    keycode_t      code_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            make_q  <= 1'b0;
            break_q <= 1'b0;
            clear_q <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= '0;
        end else begin
            make_q  <= 1'b0;
            break_q <= 1'b0;
            clear_q <= 1'b0;
            err_q   <= 1'b0;
            // A byte always beats a timeout landing in the same cycle.
            if (code_valid_i) begin
                cnt_q <= '0;
                unique case (state_q)
                    ST_IDLE: begin
                        if (code_byte_i == SC_BREAK) begin
                            state_q <= ST_BRK;
                        end else if (code_byte_i == SC_EXT) begin
                            state_q <= ST_EXT;
                        end else if (is_clear_byte(code_byte_i)) begin
                            clear_q <= 1'b1;
                        end else if (!is_ignored_byte(code_byte_i)) begin
                            make_q <= 1'b1;
                            code_q <= '{ext: 1'b0, code: code_byte_i};
                        end
                    end
                    ST_EXT: begin
                        if (code_byte_i == SC_BREAK) begin
                            state_q <= ST_EXT_BRK;
                        end else begin
                            make_q  <= 1'b1;
                            code_q  <= '{ext: 1'b1, code: code_byte_i};
                            state_q <= ST_IDLE;
                        end
                    end
                    ST_BRK: begin
                        break_q <= 1'b1;
                        code_q  <= '{ext: 1'b0, code: code_byte_i};
                        state_q <= ST_IDLE;
                    end
                    ST_EXT_BRK: begin
                        break_q <= 1'b1;
                        code_q  <= '{ext: 1'b1, code: code_byte_i};
                        state_q <= ST_IDLE;
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end else if (state_q != ST_IDLE) begin
                if (cnt_q >= CNT_LAST) begin
                    state_q <= ST_IDLE;
                    err_q   <= 1'b1;
                    cnt_q   <= '0;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

    assign make_o  = make_q;
    assign break_o = break_q;
    assign clear_o = clear_q;
    assign err_o   = err_q;
    assign code_o  = code_q;

endmodule

// File: rtl/keyboard_keymap.sv
// PS/2 Set-2 keymap: matches decoded key events against KEY_CODES and keeps
// per-key held state with press/release pulses. KEYBOARD_TYPEMATIC_EN adds key_repeat.
module keyboard_keymap
    import keyboard_pkg::*;
#(
    parameter int                    NUM_KEYS       = 2,
    parameter logic [9*NUM_KEYS-1:0] KEY_CODES      = {9'h023, 9'h01C},
    parameter int                    TIMEOUT_CYCLES = 100000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                code_valid,
    input  logic [7:0]          code_byte,
    output logic [NUM_KEYS-1:0] key_down,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic                proto_err
`ifdef KEYBOARD_TYPEMATIC_EN
    ,
    output logic [NUM_KEYS-1:0] key_repeat
`endif
);

    logic     ev_make;
    logic     ev_break;
    logic     ev_clear;
    logic     ev_err;
    keycode_t ev_code;

    keyboard_prefix_fsm #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_prefix_fsm (
        .clk          (clk),
        .rst_n        (rst_n),
        .code_valid_i (code_valid),
        .code_byte_i  (code_byte),
        .make_o       (ev_make),
        .break_o      (ev_break),
        .clear_o      (ev_clear),
        .err_o        (ev_err),
        .code_o       (ev_code)
    );

    // Duplicate table entries simply match together.
    logic [NUM_KEYS-1:0] match;

    generate
        for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_match
            assign match[gi] = (KEY_CODES[9*gi +: 9] == ev_code);
        end
    endgenerate

    logic [NUM_KEYS-1:0] down_q,    down_d;
    logic [NUM_KEYS-1:0] press_q,   press_d;
    logic [NUM_KEYS-1:0] release_q, release_d;
    logic                err_q,     err_d;
`ifdef KEYBOARD_TYPEMATIC_EN
    logic [NUM_KEYS-1:0] repeat_q,  repeat_d;
`endif

    always_comb begin
        down_d    = down_q;
        press_d   = '0;
        release_d = '0;
        err_d     = ev_err;
`ifdef KEYBOARD_TYPEMATIC_EN
        repeat_d  = '0;
`endif
        if (ev_clear) begin
            down_d    = '0;
            release_d = down_q;
        end else if (ev_make) begin
            down_d  = down_q | match;
            press_d = match & ~down_q;
`ifdef KEYBOARD_TYPEMATIC_EN
            repeat_d = match & down_q;
`endif
        end else if (ev_break) begin
            down_d    = down_q & ~match;
            release_d = match & down_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            down_q    <= '0;
            press_q   <= '0;
            release_q <= '0;
            err_q     <= 1'b0;
`ifdef KEYBOARD_TYPEMATIC_EN
            repeat_q  <= '0;
`endif
        end else begin
            down_q    <= down_d;
            press_q   <= press_d;
            release_q <= release_d;
            err_q     <= err_d;
`ifdef KEYBOARD_TYPEMATIC_EN
            repeat_q  <= repeat_d;
`endif
        end
    end

    assign key_down    = down_q;
    assign key_press   = press_q;
    assign key_release = release_q;
    assign proto_err   = err_q;
`ifdef KEYBOARD_TYPEMATIC_EN
    assign key_repeat  = repeat_q;
`endif

endmodule

// File: tb/tb_keyboard_keymap.sv
// Self-checking bench for keyboard_keymap: directed scenarios plus random byte
// streams against a prefix-aware reference model (honours KEYBOARD_TYPEMATIC_EN).
module tb_keyboard_keymap;

    localparam int NK = 3;
    localparam int T  = 20;
    localparam logic [9*NK-1:0] CODES = {9'h16B, 9'h023, 9'h01C};

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          code_valid = 1'b0;
    logic [7:0]    code_byte = 8'h00;
    logic [NK-1:0] key_down;
    logic [NK-1:0] key_press;
    logic [NK-1:0] key_release;
    logic          proto_err;
`ifdef KEYBOARD_TYPEMATIC_EN
    logic [NK-1:0] key_repeat;
`endif

    keyboard_keymap #(
        .NUM_KEYS       (NK),
        .KEY_CODES      (CODES),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .code_valid  (code_valid),
        .code_byte   (code_byte),
        .key_down    (key_down),
        .key_press   (key_press),
        .key_release (key_release),
        .proto_err   (proto_err)
`ifdef KEYBOARD_TYPEMATIC_EN
        ,
        .key_repeat  (key_repeat)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: key table, held bits, pending prefixes, expected pulses.
    logic [8:0]    m_codes [NK] = '{9'h01C, 9'h023, 9'h16B};
    logic [NK-1:0] m_held;
    logic [NK-1:0] m_press;
    logic [NK-1:0] m_rel;
    logic [NK-1:0] m_rep;
    bit            m_ext;
    bit            m_brk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_held = '0; m_press = '0; m_rel = '0; m_rep = '0;
        m_ext = 0; m_brk = 0;
    endtask

    task automatic model_key(input logic [8:0] c, input bit is_make);
        for (int i = 0; i < NK; i++) begin
            if (m_codes[i] == c) begin
                if (is_make) begin
                    if (m_held[i]) m_rep[i] = 1'b1;
                    else           m_press[i] = 1'b1;
                    m_held[i] = 1'b1;
                end else begin
                    if (m_held[i]) m_rel[i] = 1'b1;
                    m_held[i] = 1'b0;
                end
            end
        end
    endtask

    task automatic model_byte(input logic [7:0] b);
        m_press = '0; m_rel = '0; m_rep = '0;
        if (m_brk) begin
            model_key({m_ext, b}, 1'b0);
            m_ext = 0; m_brk = 0;
        end else if (b == 8'hF0) begin
            m_brk = 1;
        end else if (m_ext) begin
            model_key({1'b1, b}, 1'b1);
            m_ext = 0;
        end else if (b == 8'hE0) begin
            m_ext = 1;
        end else if (b == 8'hAA || b == 8'h00 || b == 8'hFF) begin
            m_rel  = m_held;
            m_held = '0;
        end else if (!(b == 8'hFA || b == 8'hEE || b == 8'hFE || b == 8'hE1)) begin
            model_key({1'b0, b}, 1'b1);
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".down"},    32'(key_down),    32'(m_held));
        chk({tag, ".press"},   32'(key_press),   32'(m_press));
        chk({tag, ".release"}, 32'(key_release), 32'(m_rel));
        chk({tag, ".err"},     32'(proto_err),   32'd0);
`ifdef KEYBOARD_TYPEMATIC_EN
        chk({tag, ".repeat"},  32'(key_repeat),  32'(m_rep));
`endif
    endtask

    // Called at a negedge; returns at the negedge after the result edge.
    task automatic step(input logic [7:0] b, input string tag);
        code_valid = 1'b1;
        code_byte  = b;
        @(negedge clk);
        code_valid = 1'b0;
        model_byte(b);
        @(negedge clk);
        check_outputs($sformatf("%s[%h]", tag, b));
    endtask

    initial begin
        int   wait_cyc;
        bit   seen;
        int   rep_pulses;
        int   r;
        logic [7:0] b;

        model_reset();
        #3;
        chk("reset.down",    32'(key_down),    32'd0);
        chk("reset.press",   32'(key_press),   32'd0);
        chk("reset.release", 32'(key_release), 32'd0);
        chk("reset.err",     32'(proto_err),   32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic make / break with pulse clear on the following cycle.
        step(8'h1C, "basic_make");
        @(negedge clk);
        chk("basic_press_clears", 32'(key_press), 32'd0);
        step(8'hF0, "basic_f0");
        step(8'h1C, "basic_break");

        // Simultaneous keys and typematic repeats.
        rep_pulses = 0;
        step(8'h1C, "multi");
        step(8'h23, "multi");
        step(8'h1C, "multi");
`ifdef KEYBOARD_TYPEMATIC_EN
        if (key_repeat[0]) rep_pulses++;
`endif
        step(8'h1C, "multi");
`ifdef KEYBOARD_TYPEMATIC_EN
        if (key_repeat[0]) rep_pulses++;
        chk("typematic_repeat_count", 32'(rep_pulses), 32'd2);
`endif
        chk("multi_both_held", 32'(key_down[1:0]), 32'd3);

        // Clear-all with an ignored ACK in the stream.
        step(8'hFA, "ack_ignored");
        step(8'hAA, "clear_all");
        chk("clear_release_both", 32'(key_release[1:0]), 32'd3);

        // Extended key: only E0-prefixed 6B maps; plain 6B must not.
        step(8'h6B, "plain6b");
        step(8'hE0, "ext");
        step(8'h6B, "ext_make");
        step(8'h6B, "plain6b_held");
        step(8'hE0, "ext");
        step(8'hF0, "ext");
        step(8'h6B, "ext_break");

        // Async reset while a key is held.
        step(8'h1C, "pre_reset");
        #2 rst_n = 1'b0;
        #1 chk("async_reset.down", 32'(key_down), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        step(8'hF0, "post_reset");
        step(8'h1C, "post_reset_no_release");

        // Prefix timeout: pulse near TIMEOUT_CYCLES, one cycle wide, keys kept.
        step(8'h23, "to_hold");
        step(8'hF0, "to_prefix");
        seen = 0;
        wait_cyc = 0;
        for (int j = 1; j <= 3*T; j++) begin
            @(negedge clk);
            if (proto_err === 1'b1) begin
                seen = 1;
                wait_cyc = j;
                break;
            end
        end
        chk("timeout_seen", 32'(seen), 32'd1);
        chk("timeout_latency_window", 32'(wait_cyc >= T-1 && wait_cyc <= T+1), 32'd1);
        chk("timeout_keys_kept", 32'(key_down), 32'(m_held));
        @(negedge clk);
        chk("timeout_one_cycle", 32'(proto_err), 32'd0);
        m_ext = 0; m_brk = 0;
        step(8'h23, "after_timeout_make");

        // Byte landing exactly on the timeout cycle wins; no error.
        step(8'h1C, "race_hold");
        step(8'hF0, "race_prefix");
        repeat (T-2) @(negedge clk);
        step(8'h1C, "race_break");
        repeat (3) begin
            @(negedge clk);
            chk("race_no_err", 32'(proto_err), 32'd0);
        end

        // Randomized byte stream against the model.
        for (int k = 0; k < 250; k++) begin
            r = $urandom_range(0, 13);
            case (r)
                0, 1:  b = 8'h1C;
                2, 3:  b = 8'h23;
                4:     b = 8'h6B;
                5, 6:  b = 8'hF0;
                7, 8:  b = 8'hE0;
                9:     b = 8'hAA;
                10:    b = 8'hFA;
                11:    b = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'hFF;
                default: b = 8'($urandom_range(0, 255));
            endcase
            step(b, $sformatf("rand%0d", k));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
